// File: rtl/mult_8x8_acc_stage_if.sv
// Handshake bundle for mult_8x8_acc_stage: product beats in, frame results out.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface mult_8x8_acc_stage_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 9
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_prod;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_acc,
        input  out_cnt,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_acc,
        output out_cnt,
        output out_ovf
    );
endinterface

// File: rtl/mult_8x8_acc_stage.sv
// Frame accumulator for 16-bit approximate-multiplier products, result on a valid/ready port.
// Define MULT_ACC_SAT_EN to clamp the sum at 2^ACC_W-1 instead of wrapping on overflow.
module mult_8x8_acc_stage #(
    parameter int ACC_W     = 24,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    mult_8x8_acc_stage_if.slave    bus
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TERMS);

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [ACC_W-1:0] acc_q,   acc_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic             in_ready;
    logic             out_valid;
    logic             beat_acc;
    logic             out_take;
    logic             frame_close;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W:0]   sum_wide;

    // One extra bit so the carry out of the accumulator is visible.
    function automatic logic [ACC_W:0] add_wide(input logic [ACC_W-1:0] a,
                                                input logic [15:0]      p);
        return {1'b0, a} + (ACC_W+1)'(p);
    endfunction

    // Once clamped the sum is all ones, so any further non-zero term carries again
    // and zero terms leave it alone: the clamp is sticky without extra state.
    function automatic logic [ACC_W-1:0] fold_sum(input logic [ACC_W:0] s);
`ifdef MULT_ACC_SAT_EN
        return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
`else
        return s[ACC_W-1:0];
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
            first_q <= 1'b1;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (beat_acc && frame_close) state_d = ST_DONE;
            ST_DONE: if (out_take)                state_d = ST_ACC;
            default:                              state_d = ST_ACC;
        endcase
    end

    // Handshake outputs depend only on the state register.
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        beat_acc    = bus.in_valid && in_ready;
        out_take    = out_valid && bus.out_ready;
        cnt_next    = first_q ? CNT_ONE : (cnt_q + CNT_ONE);
        frame_close = bus.in_last || (cnt_next == CNT_MAX);
        sum_wide    = add_wide(acc_q, bus.in_prod);
    end

    always_comb begin
        first_d = first_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (beat_acc) begin
            first_d = 1'b0;
            cnt_d   = cnt_next;
            if (first_q) begin
                acc_d = ACC_W'(bus.in_prod);
                ovf_d = 1'b0;
            end else begin
                acc_d = fold_sum(sum_wide);
                ovf_d = ovf_q | sum_wide[ACC_W];
            end
        end
        // The result registers keep showing the last frame until a new beat arrives.
        if (out_take) begin
            first_d = 1'b1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_acc   = acc_q;
    assign bus.out_cnt   = cnt_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_mult_8x8_acc_stage.sv
// Scoreboard bench for mult_8x8_acc_stage: directed boundary frames, then random frames.
module tb_mult_8x8_acc_stage;

    localparam int     ACC_W     = 18;
    localparam int     MAX_TERMS = 8;
    localparam int     CNT_W     = 4;
    localparam longint MAXV      = (longint'(1) << ACC_W) - 1;

    typedef struct {
        longint acc;
        longint cnt;
        longint ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_8x8_acc_stage_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mult_8x8_acc_stage #(
        .ACC_W    (ACC_W),
        .MAX_TERMS(MAX_TERMS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t   sb_q[$];
    int     errors     = 0;
    int     checks     = 0;
    int     mode       = 0;   // 0: consumer always ready, 1: stalled, 2: random
    int     frames_in  = 0;
    int     frames_out = 0;
    longint fsum       = 0;
    int     fcnt       = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: plain sum of the frame's products, then wrap or clamp.
    function automatic void model_accept(input longint p, input bit l);
        exp_t e;
        fsum += p;
        fcnt++;
        if (l || fcnt == MAX_TERMS) begin
            e.ovf = (fsum > MAXV) ? 1 : 0;
`ifdef MULT_ACC_SAT_EN
            e.acc = (fsum > MAXV) ? MAXV : fsum;
`else
            e.acc = fsum % (MAXV + 1);
`endif
            e.cnt = fcnt;
            sb_q.push_back(e);
            frames_in++;
            fsum = 0;
            fcnt = 0;
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send(input logic [15:0] p, input bit l);
        int guard;
        guard = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_last  = l;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0d after %0d cycles, expected 1", bus.in_ready, guard);
            bus.in_valid = 1'b0;
            return;
        end
        model_accept(longint'(p), l);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  longint'(bus.in_ready),  1);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_out_acc"},   longint'(bus.out_acc),   0);
        check({tag, "_out_cnt"},   longint'(bus.out_cnt),   0);
        check({tag, "_out_ovf"},   longint'(bus.out_ovf),   0);
    endtask

    logic rst_at_edge = 1'b0;
    logic hold_prev   = 1'b0;
    always @(posedge clk) rst_at_edge <= rst;

    // Monitor: drives out_ready, compares presented results against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (hold_prev && !rst_at_edge)
            check("out_valid_held", longint'(bus.out_valid), 1);
        case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got acc=%0d cnt=%0d, expected no result", bus.out_acc, bus.out_cnt);
            end else begin
                e = sb_q[0];
                check("sb_acc", longint'(bus.out_acc), e.acc);
                check("sb_cnt", longint'(bus.out_cnt), e.cnt);
                check("sb_ovf", longint'(bus.out_ovf), e.ovf);
                if (bus.out_ready) begin
                    void'(sb_q.pop_front());
                    frames_out++;
                end
            end
        end
        hold_prev = bus.out_valid && !bus.out_ready;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int     len;
        int     guard;
        logic [15:0] p;

        bus.in_valid = 1'b0;
        bus.in_prod  = '0;
        bus.in_last  = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 100+200+300: result one cycle after the last accept, one bubble only.
        send(16'd100, 1'b0);
        send(16'd200, 1'b0);
        send(16'd300, 1'b1);
        check("t1_out_valid_latency", longint'(bus.out_valid), 1);
        check("t1_in_ready_done",     longint'(bus.in_ready),  0);
        @(negedge clk);
        check("t1_in_ready_back",     longint'(bus.in_ready),  1);
        check("t1_out_valid_drop",    longint'(bus.out_valid), 0);

        // Single-beat frame held by a stalled consumer with a new beat pending.
        repeat (2) @(negedge clk);
        mode = 1;
        @(negedge clk);
        send(16'd65025, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_prod  = 16'd5;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid",    longint'(bus.out_valid), 1);
            check("t2_hold_in_ready", longint'(bus.in_ready),  0);
            check("t2_hold_acc",      longint'(bus.out_acc),   65025);
            check("t2_hold_cnt",      longint'(bus.out_cnt),   1);
            @(negedge clk);
        end
        mode = 0;
        send(16'd5, 1'b1);
        repeat (2) @(negedge clk);

        // Forced close after MAX_TERMS beats without in_last.
        for (int i = 0; i < MAX_TERMS; i++) send(16'd1, 1'b0);
        check("t3_forced_valid", longint'(bus.out_valid), 1);
        check("t3_forced_cnt",   longint'(bus.out_cnt),   MAX_TERMS);
        check("t3_forced_acc",   longint'(bus.out_acc),   MAX_TERMS);
        send(16'd2, 1'b1);
        repeat (2) @(negedge clk);

        // Five maximal products overflow an 18-bit accumulator.
        for (int i = 0; i < 5; i++) send(16'd65535, (i == 4));
`ifdef MULT_ACC_SAT_EN
        check("t4_ovf_acc", longint'(bus.out_acc), 262143);
`else
        check("t4_ovf_acc", longint'(bus.out_acc), 65531);
`endif
        check("t4_ovf_flag", longint'(bus.out_ovf), 1);
        repeat (2) @(negedge clk);

        // Reset mid-frame discards the partial sum.
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5_midrst");
        rst  = 1'b0;
        fsum = 0;
        fcnt = 0;
        @(negedge clk);
        check("t5_no_output", longint'(bus.out_valid), 0);
        send(16'd7, 1'b1);
        repeat (2) @(negedge clk);

        // Reset while a result is waiting drops it.
        mode = 1;
        @(negedge clk);
        send(16'd9, 1'b1);
        check("t6_done_valid", longint'(bus.out_valid), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb_q.pop_back());
        frames_in--;
        check_reset_outputs("t6_donerst");
        mode = 0;
        @(negedge clk);

        // Random frames, gaps and back-pressure.
        mode = 2;
        for (int f = 0; f < 1000; f++) begin
            len = $urandom_range(1, 10);
            for (int b = 0; b < len; b++) begin
                case ($urandom_range(0, 9))
                    0:       p = 16'd0;
                    1:       p = 16'hFFFF;
                    default: p = 16'($urandom_range(0, 65535));
                endcase
                send(p, (b == len - 1));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
        end

        mode  = 0;
        guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check("drain_queue_empty", longint'(sb_q.size()), 0);
        check("frames_out_count",  longint'(frames_out), longint'(frames_in));
        check("final_out_valid",   longint'(bus.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
